window_stream: RTL and testbench



---
 rtl/window_stream.sv | 245 ++++++++++++++++++++++++
 tb/tb_window_stream.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream.sv
// window_stream: streaming multi-channel KxK sliding-window generator.
// A raster pixel stream is written into a (KERNEL_SIZE+1)-row ring line
// buffer; one flattened KxKxCHANNELS window is emitted per output transfer,
// with centers stepping by STRIDE and borders SAME-padded.
// Optional build macro: WINDOW_REPLICATE_PAD_EN selects border replication
// (coordinates clamped into the image) instead of zero padding.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high; once valid is raised it, and its payload,
// hold until that transfer.
module window_stream #(
   parameter int DATA_WIDTH  = 16,
   parameter int CHANNELS    = 3,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32,
   parameter int KERNEL_SIZE = 3,
   parameter int STRIDE      = 1
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic [CHANNELS*DATA_WIDTH-1:0]                         in_data,
   input  logic                                                   in_valid,
   input  logic                                                   in_sof,
   output logic                                                   in_ready,
   output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] out_data,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [$clog2(IMG_WIDTH)-1:0]                           out_x,
   output logic [$clog2(IMG_HEIGHT)-1:0]                          out_y,
   output logic                                                   out_last,
   output logic                                                   frame_done,
   output logic                                                   err_sof,
   output logic [1:0]                                             state_dbg
);

   localparam int PADDING = (KERNEL_SIZE - 1) / 2;
   localparam int PW      = CHANNELS * DATA_WIDTH;
   localparam int OW      = KERNEL_SIZE * KERNEL_SIZE * PW;
   localparam int RING    = KERNEL_SIZE + 1;
   localparam int RW      = $clog2(RING);
   localparam int XW      = $clog2(IMG_WIDTH);
   localparam int YW      = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t state, state_next;

   // Ring line buffer: row y of the frame lives in ring row y mod RING.
   logic [PW-1:0] line_mem [RING][IMG_WIDTH];

   // Input position of the next pixel to be written; y_in reaches
   // IMG_HEIGHT once the whole frame has been accepted.
   logic [XW-1:0] x_in;
   logic [YW:0]   y_in;
   logic [RW-1:0] wr_row;

   // Center of the next window to load into the output register.
   logic [XW-1:0] xw;
   logic [YW-1:0] yw;
   logic          scan_done;

   logic          in_fire;
   logic          out_fire;
   logic          win_avail;
   logic          win_last;
   logic          in_stall;
   logic          load_en;
   int            need_x;
   int            need_y;
   logic [OW-1:0] win_data;
   logic [RW-1:0] wr_row_sel;
   logic [XW-1:0] wr_col_sel;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign state_dbg = state;

   // Read one pixel of the current window; out-of-image coordinates are
   // either zero or clamped to the nearest edge pixel.
   function automatic logic [PW-1:0] fetch(input int row, input int col);
      int r;
      int c;
      logic [PW-1:0] px;
      r  = row;
      c  = col;
      px = '0;
`ifdef WINDOW_REPLICATE_PAD_EN
      if (r < 0) r = 0;
      if (r > IMG_HEIGHT - 1) r = IMG_HEIGHT - 1;
      if (c < 0) c = 0;
      if (c > IMG_WIDTH - 1) c = IMG_WIDTH - 1;
      px = line_mem[RW'(r % RING)][XW'(c)];
`else
      if (r >= 0 && r < IMG_HEIGHT && c >= 0 && c < IMG_WIDTH)
         px = line_mem[RW'(r % RING)][XW'(c)];
`endif
      return px;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and input ready.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && in_sof) state_next = FILL;
         end
         FILL: begin
            in_ready = !in_stall;
            if (win_avail) state_next = RUN;
         end
         RUN: begin
            in_ready = !in_stall;
            if (out_fire && out_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) in_ready = 1'b0;
   end

   // Window availability, ring-overwrite stall and end-of-scan detection.
   always_comb begin
      need_x = int'(xw) + PADDING;
      if (need_x > IMG_WIDTH - 1) need_x = IMG_WIDTH - 1;
      need_y = int'(yw) + PADDING;
      if (need_y > IMG_HEIGHT - 1) need_y = IMG_HEIGHT - 1;
      win_avail = (state != IDLE) && !scan_done &&
                  ((int'(y_in) > need_y) ||
                   ((int'(y_in) == need_y) && (int'(x_in) > need_x)));
      // Writing row y_in reuses the ring row of y_in-RING, which must be
      // older than the top row of the next window.
      in_stall  = (int'(y_in) >= int'(yw) - PADDING + RING) ||
                  (int'(y_in) >= IMG_HEIGHT);
      win_last  = (int'(xw) + STRIDE >= IMG_WIDTH) &&
                  (int'(yw) + STRIDE >= IMG_HEIGHT);
      load_en   = win_avail && (!out_valid || out_ready);
   end

   // Gather and pack the window; element (i,j) pixel goes to slot i*K+j,
   // slot 0 in the MSBs, channel 0 first within each pixel.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
         for (int j = 0; j < KERNEL_SIZE; j++) begin
            win_data[(KERNEL_SIZE*KERNEL_SIZE-1-(i*KERNEL_SIZE+j))*PW +: PW] =
               fetch(int'(yw) + i - PADDING, int'(xw) + j - PADDING);
         end
      end
   end

   // Write address: the start-of-frame pixel always lands at (0,0).
   always_comb begin
      wr_row_sel = wr_row;
      wr_col_sel = x_in;
      if (state == IDLE) begin
         wr_row_sel = '0;
         wr_col_sel = '0;
      end
   end

   // Line buffer write; contents need no reset.
   always_ff @(posedge clk) begin
      if (in_fire && (state != IDLE || in_sof))
         line_mem[wr_row_sel][wr_col_sel] <= in_data;
   end

   // Input raster counters and the sticky mid-frame sof flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_in    <= '0;
         y_in    <= '0;
         wr_row  <= '0;
         err_sof <= 1'b0;
      end else if (in_fire) begin
         if (state == IDLE) begin
            if (in_sof) begin
               x_in   <= XW'(1);
               y_in   <= '0;
               wr_row <= '0;
            end
         end else begin
            if (int'(x_in) == IMG_WIDTH - 1) begin
               x_in   <= '0;
               y_in   <= y_in + (YW+1)'(1);
               wr_row <= (int'(wr_row) == RING - 1) ? '0 : wr_row + RW'(1);
            end else begin
               x_in <= x_in + XW'(1);
            end
            if (in_sof) err_sof <= 1'b1;
         end
      end
   end

   // Scan counters, single-entry output register and frame_done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         xw         <= '0;
         yw         <= '0;
         scan_done  <= 1'b0;
      end else begin
         frame_done <= out_fire && out_last;
         if (state == IDLE && in_fire && in_sof) begin
            xw        <= '0;
            yw        <= '0;
            scan_done <= 1'b0;
         end
         if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_x     <= xw;
            out_y     <= yw;
            out_last  <= win_last;
            if (win_last) begin
               scan_done <= 1'b1;
            end else if (int'(xw) + STRIDE >= IMG_WIDTH) begin
               xw <= '0;
               yw <= yw + YW'(STRIDE);
            end else begin
               xw <= xw + XW'(STRIDE);
            end
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window_stream.sv
// Bench for window_stream: two 4x4 instances (C=1/S=1 and C=2/S=2),
// scoreboard queues filled by the stimulus, independent output monitors.
module tb_window_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: C=1, S=1
   logic [15:0]  a_in_data;
   logic         a_in_valid, a_in_sof, a_in_ready;
   logic [143:0] a_out_data;
   logic         a_out_valid, a_out_ready, a_out_last, a_frame_done, a_err_sof;
   logic [1:0]   a_out_x, a_out_y, a_state;

   // Instance B: C=2, S=2
   logic [31:0]  b_in_data;
   logic         b_in_valid, b_in_sof, b_in_ready;
   logic [287:0] b_out_data;
   logic         b_out_valid, b_out_ready, b_out_last, b_frame_done, b_err_sof;
   logic [1:0]   b_out_x, b_out_y, b_state;

   window_stream #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4),
                   .KERNEL_SIZE(3), .STRIDE(1)) u_a (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_sof(a_in_sof), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_x(a_out_x),
      .out_y(a_out_y), .out_last(a_out_last), .frame_done(a_frame_done),
      .err_sof(a_err_sof), .state_dbg(a_state));

   window_stream #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4),
                   .KERNEL_SIZE(3), .STRIDE(2)) u_b (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_sof(b_in_sof), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_x(b_out_x),
      .out_y(b_out_y), .out_last(b_out_last), .frame_done(b_frame_done),
      .err_sof(b_err_sof), .state_dbg(b_state));

   // Hand-computed windows
`ifdef WINDOW_REPLICATE_PAD_EN
   localparam int A00[9] = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
   localparam int A33[9] = '{11, 12, 12, 15, 16, 16, 15, 16, 16};
`else
   localparam int A00[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
   localparam int A33[9] = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
`endif
   localparam int B22[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};

   int n_checks = 0;
   int n_fail   = 0;

   logic [148:0] exp_a_q[$];
   logic [292:0] exp_b_q[$];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur within its bound", name);
   endtask

   // Reference pixel model: value y*4+x+1, padded per build.
   function automatic int pix_val(input int yy, input int xx);
      int y;
      int x;
      y = yy;
      x = xx;
`ifdef WINDOW_REPLICATE_PAD_EN
      if (y < 0) y = 0;
      if (y > 3) y = 3;
      if (x < 0) x = 0;
      if (x > 3) x = 3;
`else
      if (y < 0 || y > 3 || x < 0 || x > 3) return 0;
`endif
      return y * 4 + x + 1;
   endfunction

   function automatic logic [143:0] model_a(input int xw, input int yw);
      logic [143:0] v;
      v = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v[(8 - (i*3 + j))*16 +: 16] = 16'(pix_val(yw + i - 1, xw + j - 1));
      return v;
   endfunction

   function automatic logic [287:0] model_b(input int xw, input int yw);
      logic [287:0] v;
      int p;
      v = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            p = pix_val(yw + i - 1, xw + j - 1);
            v[(17 - (i*3 + j)*2)*16 +: 16] = 16'(p);
            v[(17 - (i*3 + j)*2 - 1)*16 +: 16] = (p == 0) ? 16'd0 : 16'(p + 100);
         end
      return v;
   endfunction

   function automatic logic [143:0] pack_a9(input int e[9]);
      logic [143:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v[(8 - k)*16 +: 16] = 16'(e[k]);
      return v;
   endfunction

   function automatic logic [287:0] pack_b9(input int e[9]);
      logic [287:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         v[(17 - 2*k)*16 +: 16]     = 16'(e[k]);
         v[(17 - 2*k - 1)*16 +: 16] = 16'(e[k] + 100);
      end
      return v;
   endfunction

   task automatic push_frame_a();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            exp_a_q.push_back({(x == 3 && y == 3), 2'(y), 2'(x), model_a(x, y)});
   endtask

   task automatic push_frame_b();
      for (int y = 0; y < 4; y += 2)
         for (int x = 0; x < 4; x += 2)
            exp_b_q.push_back({(x == 2 && y == 2), 2'(y), 2'(x), model_b(x, y)});
   endtask

   // Drive one pixel and wait (bounded) for its acceptance.
   task automatic send_px(input bit inst, input int v, input bit sof);
      int g;
      g = 0;
      @(negedge clk);
      if (inst == 1'b0) begin
         a_in_data = 16'(v); a_in_sof = sof; a_in_valid = 1'b1;
      end else begin
         b_in_data = {16'(v), 16'(v + 100)}; b_in_sof = sof; b_in_valid = 1'b1;
      end
      while (((inst == 1'b0) ? !a_in_ready : !b_in_ready) && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 1000) note_fail("in_ready_wait");
      @(posedge clk);
      #1;
      a_in_valid = 1'b0; a_in_sof = 1'b0;
      b_in_valid = 1'b0; b_in_sof = 1'b0;
   endtask

   task automatic send_frame(input bit inst, input int glitch_idx);
      for (int k = 0; k < 16; k++) send_px(inst, k + 1, (k == 0) || (k == glitch_idx));
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && g < 600) begin
         @(negedge clk);
         g++;
      end
      if (g >= 600) note_fail(name);
      repeat (4) @(negedge clk);
   endtask

   // Monitor A
   logic [148:0] cur_a, prev_a, got_a;
   bit hold_a = 0, pend_a = 0;
   int done_cnt_a = 0;
   always @(negedge clk) begin
      if (pend_a) begin
         check("a_frame_done_after_last", 512'(a_frame_done), 512'(1));
         check("a_idle_in_ready", 512'(a_in_ready), 512'(1));
      end
      pend_a = 1'b0;
      if (a_frame_done === 1'b1) done_cnt_a++;
      if (a_out_valid === 1'b1) begin
         cur_a = {a_out_last, a_out_y, a_out_x, a_out_data};
         if (hold_a) check("a_hold_stable", 512'(cur_a), 512'(prev_a));
         if (a_out_ready) begin
            if (exp_a_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_unexpected_window: got %0h expected none", cur_a);
            end else begin
               got_a = exp_a_q.pop_front();
               check("a_window", 512'(cur_a), 512'(got_a));
               if (a_out_x == 2'd0 && a_out_y == 2'd0)
                  check("a_win00_hand", 512'(a_out_data), 512'(pack_a9(A00)));
               if (a_out_x == 2'd3 && a_out_y == 2'd3)
                  check("a_win33_hand", 512'(a_out_data), 512'(pack_a9(A33)));
            end
            pend_a = a_out_last;
         end
         hold_a = !a_out_ready;
         prev_a = cur_a;
      end else begin
         hold_a = 1'b0;
      end
   end

   // Monitor B
   logic [292:0] cur_b, got_b;
   bit pend_b = 0;
   int done_cnt_b = 0;
   always @(negedge clk) begin
      if (pend_b) check("b_frame_done_after_last", 512'(b_frame_done), 512'(1));
      pend_b = 1'b0;
      if (b_frame_done === 1'b1) done_cnt_b++;
      if (b_out_valid === 1'b1 && b_out_ready) begin
         cur_b = {b_out_last, b_out_y, b_out_x, b_out_data};
         if (exp_b_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_unexpected_window: got %0h expected none", cur_b);
         end else begin
            got_b = exp_b_q.pop_front();
            check("b_window", 512'(cur_b), 512'(got_b));
            if (b_out_x == 2'd2 && b_out_y == 2'd2)
               check("b_win22_hand", 512'(b_out_data), 512'(pack_b9(B22)));
            if (b_out_x == 2'd0 && b_out_y == 2'd0) begin
               check("b_win00_center_c0", 512'(b_out_data[9*16 +: 16]), 512'(1));
               check("b_win00_center_c1", 512'(b_out_data[8*16 +: 16]), 512'(101));
            end
         end
         pend_b = b_out_last;
      end
   end

   bit saw_stall;

   initial begin
      rst = 1'b1;
      a_in_data = '0; a_in_valid = 1'b0; a_in_sof = 1'b0; a_out_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 512'(a_out_valid), 512'(0));
      check("rst_out_data", 512'(a_out_data), 512'(0));
      check("rst_out_xy", 512'({a_out_x, a_out_y}), 512'(0));
      check("rst_out_last", 512'(a_out_last), 512'(0));
      check("rst_frame_done", 512'(a_frame_done), 512'(0));
      check("rst_err_sof", 512'(a_err_sof), 512'(0));
      check("rst_in_ready", 512'(a_in_ready), 512'(0));
      check("rst_state", 512'(a_state), 512'(0));
      check("rst_b_out_valid", 512'(b_out_valid), 512'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 512'(a_in_ready), 512'(1));

      // Pixels without sof in IDLE are dropped.
      for (int k = 0; k < 3; k++) send_px(1'b0, 50 + k, 1'b0);
      repeat (6) @(negedge clk);
      check("idle_discard_valid", 512'(a_out_valid), 512'(0));
      check("idle_discard_state", 512'(a_state), 512'(0));

      // Frame 1: free-flowing output.
      push_frame_a();
      send_frame(1'b0, -1);
      drain("a_frame1_drain");
      check("a_frame1_done_cnt", 512'(done_cnt_a), 512'(1));
      check("a_frame1_err_sof", 512'(a_err_sof), 512'(0));

      // Frame 2: consumer stalls 20 cycles early in the frame.
      push_frame_a();
      saw_stall = 1'b0;
      fork
         send_frame(1'b0, -1);
         begin
            repeat (3) @(posedge clk);
            #1 a_out_ready = 1'b0;
            repeat (20) begin
               @(negedge clk);
               if (!a_in_ready) saw_stall = 1'b1;
            end
            check("a_bp_window_held", 512'(a_out_valid), 512'(1));
            @(posedge clk);
            #1 a_out_ready = 1'b1;
         end
      join
      check("a_bp_in_ready_dropped", 512'(saw_stall), 512'(1));
      drain("a_frame2_drain");
      check("a_frame2_done_cnt", 512'(done_cnt_a), 512'(2));

      // Frame 3: sof repeated mid-frame.
      push_frame_a();
      send_frame(1'b0, 5);
      check("a_err_sof_set", 512'(a_err_sof), 512'(1));
      drain("a_frame3_drain");
      check("a_err_sof_sticky", 512'(a_err_sof), 512'(1));

      // Frame 4: aborted by reset after nine pixels.
      push_frame_a();
      for (int k = 0; k < 9; k++) send_px(1'b0, k + 1, k == 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_out_valid", 512'(a_out_valid), 512'(0));
      check("abort_err_sof_clear", 512'(a_err_sof), 512'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      exp_a_q.delete();
      repeat (4) @(negedge clk);
      check("abort_no_output", 512'(a_out_valid), 512'(0));

      // Frame 5: clean frame after abort.
      push_frame_a();
      send_frame(1'b0, -1);
      drain("a_frame5_drain");
      check("a_total_done_cnt", 512'(done_cnt_a), 512'(4));

      // Instance B: two channels, stride 2.
      push_frame_b();
      send_frame(1'b1, -1);
      drain("b_frame_drain");
      check("b_done_cnt", 512'(done_cnt_b), 512'(1));
      check("b_err_sof", 512'(b_err_sof), 512'(0));

      check("a_queue_empty", 512'(exp_a_q.size()), 512'(0));
      check("b_queue_empty", 512'(exp_b_q.size()), 512'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
